// File: rtl/mul_issue_ctrl.sv
// EX-stage sequencer for the shared iterative multiplier: accepts one M-extension request,
// issues it or serves it from a one-entry result cache, stalls the pipe, and writes the result back.
module mul_issue_ctrl #(
  parameter int XLEN     = 32,
  parameter int TIMEOUT  = 40,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_is_mul,
  input  logic [1:0]      ex_op,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic            start_m,
  output logic [1:0]      m_op,
  output logic [XLEN-1:0] m_opa,
  output logic [XLEN-1:0] m_opb,
  input  logic            m_done,
  input  logic [XLEN-1:0] m_result,
  output logic            stall,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            timeout_err,
  output logic [2:0]      dbg_state,
  output logic            dbg_cache_valid
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HIT   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [1:0]      r_op;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_wb_data;
  logic            r_kill;
  logic [CW-1:0]   r_cnt;

  logic            r_cache_valid;
  logic [1:0]      r_tag_op;
  logic [XLEN-1:0] r_tag_rs1;
  logic [XLEN-1:0] r_tag_rs2;
  logic [XLEN-1:0] r_cache_data;

  logic            w_acc;
  logic            w_hit;
  logic            w_done;
  logic            w_start;
  logic            w_stall;
  logic            w_wb_valid;
  logic            w_timeout;

  // Handshake: a request is taken in any IDLE cycle where ex_valid & ex_is_mul are high
  // and flush is low; stall is the back-pressure that holds EX until the HIT/RESP beat.
  assign w_acc  = ex_valid & ex_is_mul & ~flush & (r_state == S_IDLE);
  assign w_hit  = CACHE_EN & r_cache_valid & (ex_op == r_tag_op) &
                  (ex_rs1 == r_tag_rs1) & (ex_rs2 == r_tag_rs2);
  assign w_done = (r_state == S_WAIT) & m_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_stall    = w_acc;
    w_wb_valid = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_next = w_hit ? S_HIT : S_ISSUE;
        end
      end
      S_HIT: begin
        w_wb_valid = ~flush;
        w_next     = S_IDLE;
      end
      S_ISSUE: begin
        w_start = 1'b1;
        w_stall = 1'b1;
        w_next  = S_WAIT;
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (m_done) begin
          w_next = S_RESP;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_RESP: begin
        w_wb_valid = ~flush & ~r_kill;
        w_next     = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Request latch; m_op/m_opa/m_opb only change on accept, so they hold through WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= 2'd0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= 5'd0;
      r_wb_data <= '0;
    end else begin
      if (w_acc) begin
        r_op  <= ex_op;
        r_rs1 <= ex_rs1;
        r_rs2 <= ex_rs2;
        r_rd  <= ex_rd;
        if (w_hit) begin
          r_wb_data <= r_cache_data;
        end
      end
      if (w_done) begin
        r_wb_data <= m_result;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_kill <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == S_IDLE) begin
        r_kill <= 1'b0;
      end else if (flush && (r_state == S_ISSUE || r_state == S_WAIT)) begin
        r_kill <= 1'b1;
      end
    end
  end

  // A killed request still refreshes the cache: the multiplier result is correct regardless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cache_valid <= 1'b0;
      r_tag_op      <= 2'd0;
      r_tag_rs1     <= '0;
      r_tag_rs2     <= '0;
      r_cache_data  <= '0;
    end else begin
      if (w_done) begin
        r_cache_valid <= 1'b1;
        r_tag_op      <= r_op;
        r_tag_rs1     <= r_rs1;
        r_tag_rs2     <= r_rs2;
        r_cache_data  <= m_result;
      end else if (w_timeout) begin
        r_cache_valid <= 1'b0;
      end
    end
  end

  assign start_m         = w_start;
  assign stall           = w_stall;
  assign wb_valid        = w_wb_valid;
  assign timeout_err     = w_timeout;
  assign m_op            = r_op;
  assign m_opa           = r_rs1;
  assign m_opb           = r_rs2;
  assign wb_rd           = r_rd;
  assign wb_data         = r_wb_data;
  assign dbg_state       = r_state;
  assign dbg_cache_valid = r_cache_valid;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: a behavioural 33-cycle multiplier plus a writeback scoreboard
// keyed on {cycle, rd, data}; each scenario task checks its own control-path observations.
module tb_mul_issue_ctrl;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 40;
  localparam int MUL_LAT = 33;
  localparam int W       = 32 + 5 + XLEN;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_valid;
  logic            ex_is_mul;
  logic [1:0]      ex_op;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;
  logic [4:0]      ex_rd;
  logic            flush;
  logic            start_m;
  logic [1:0]      m_op;
  logic [XLEN-1:0] m_opa;
  logic [XLEN-1:0] m_opb;
  logic            m_done;
  logic [XLEN-1:0] m_result;
  logic            stall;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            timeout_err;
  logic [2:0]      dbg_state;
  logic            dbg_cache_valid;

  logic            spur_done;
  logic            mdl_silent;
  logic            mdl_done;
  logic            mdl_busy;
  logic [XLEN-1:0] mdl_res;
  int              mdl_cnt;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;
  int last_start_cyc = -1;
  int to_cnt = 0;
  int last_to_cyc = -1;
  logic [W-1:0] exp_q[$];

  assign m_done   = mdl_done | spur_done;
  assign m_result = mdl_res;

  mul_issue_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .CACHE_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_mul(ex_is_mul), .ex_op(ex_op),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .flush(flush), .start_m(start_m),
    .m_op(m_op), .m_opa(m_opa), .m_opb(m_opb), .m_done(m_done), .m_result(m_result),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .timeout_err(timeout_err), .dbg_state(dbg_state), .dbg_cache_valid(dbg_cache_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mul_ref(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00:   begin p = ua * ub; return p[31:0];  end
      2'b01:   begin p = sa * sb; return p[63:32]; end
      2'b10:   begin p = sa * ub; return p[63:32]; end
      default: begin p = ua * ub; return p[63:32]; end
    endcase
  endfunction

  // m_done arrives MUL_LAT cycles after the start_m cycle, result computed from the registered operands.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_busy <= 1'b0;
      mdl_done <= 1'b0;
      mdl_cnt  <= 0;
      mdl_res  <= '0;
    end else begin
      mdl_done <= 1'b0;
      if (mdl_busy) begin
        if (mdl_cnt == 0) begin
          mdl_done <= 1'b1;
          mdl_busy <= 1'b0;
        end else begin
          mdl_cnt <= mdl_cnt - 1;
        end
      end else if (start_m && !mdl_silent) begin
        mdl_busy <= 1'b1;
        mdl_cnt  <= MUL_LAT - 1;
        mdl_res  <= mul_ref(m_op, m_opa, m_opb);
      end
    end
  end

  // Advance one cycle, sampling at the falling edge and servicing the writeback scoreboard.
  task automatic tick();
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    @(negedge clk);
    if (start_m === 1'b1) begin
      start_cnt++;
      last_start_cyc = cyc;
    end
    if (timeout_err === 1'b1) begin
      to_cnt++;
      last_to_cyc = cyc;
    end
    if (wb_valid === 1'b1) begin
      n_cmp++;
      act_v = {32'(cyc), wb_rd, wb_data};
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wb_unexpected: got cycle %0d rd %0d data %h, required no writeback",
                 cyc, wb_rd, wb_data);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v) begin
          n_err++;
          $display("FAIL wb_beat: got cycle/rd/data %0d/%0d/%h, required %0d/%0d/%h",
                   cyc, wb_rd, wb_data, exp_v[W-1 -: 32], exp_v[XLEN+4 -: 5], exp_v[XLEN-1:0]);
        end
      end
    end else if (exp_q.size() != 0) begin
      exp_v = exp_q[0];
      if (int'(exp_v[W-1 -: 32]) <= cyc) begin
        n_cmp++;
        n_err++;
        void'(exp_q.pop_front());
        $display("FAIL wb_missing: got no writeback at cycle %0d, required rd %0d data %h",
                 cyc, exp_v[XLEN+4 -: 5], exp_v[XLEN-1:0]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int acc_cyc, output logic st);
    ex_valid = 1'b1; ex_is_mul = 1'b1; ex_op = op; ex_rs1 = a; ex_rs2 = b; ex_rd = rd;
    acc_cyc = cyc;
    #1 st = stall;
    tick();
    ex_valid = 1'b0; ex_is_mul = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_valid = 1'b0; ex_is_mul = 1'b0; ex_op = 2'd0; ex_rs1 = '0; ex_rs2 = '0;
    ex_rd = 5'd0; flush = 1'b0; spur_done = 1'b0; mdl_silent = 1'b0;
    tick(); tick();
    #1;
    n_cmp++;
    if ({start_m, stall, wb_valid, timeout_err} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_strobes: got %b, required 0000", {start_m, stall, wb_valid, timeout_err});
    end
    n_cmp++;
    if ({m_op, m_opa, m_opb, wb_rd, wb_data} !== '0) begin
      n_err++;
      $display("FAIL reset_regs: got op %0d opa %h opb %h rd %0d data %h, required all 0",
               m_op, m_opa, m_opb, wb_rd, wb_data);
    end
    n_cmp++;
    if (dbg_state !== 3'd0 || dbg_cache_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got state %0d cache %b, required 0/0", dbg_state, dbg_cache_valid);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_miss_mul();
    int a, s0, bad;
    logic st;
    s0 = start_cnt; bad = 0;
    issue(2'b00, 32'd7, 32'd6, 5'd5, a, st);
    exp_q.push_back({32'(a + MUL_LAT + 3), 5'd5, 32'd42});
    n_cmp++;
    if (st !== 1'b1) begin
      n_err++;
      $display("FAIL miss_stall_accept: got %b, required 1", st);
    end
    while (cyc <= a + MUL_LAT + 4) begin
      #1;
      if (stall !== (cyc <= a + MUL_LAT + 2)) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL miss_stall_window: got %0d wrong cycles, required 0", bad);
    end
    n_cmp++;
    if (start_cnt - s0 != 1 || last_start_cyc != a + 1) begin
      n_err++;
      $display("FAIL miss_start: got %0d pulses last at %0d, required 1 at %0d",
               start_cnt - s0, last_start_cyc, a + 1);
    end
  endtask

  task automatic test_hit_then_op_miss();
    int a, b, s0;
    logic st;
    s0 = start_cnt;
    issue(2'b00, 32'd7, 32'd6, 5'd9, a, st);
    exp_q.push_back({32'(a + 1), 5'd9, 32'd42});
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL hit_stall: got %b in HIT, required 0", stall);
    end
    tick();
    issue(2'b11, 32'd7, 32'd6, 5'd3, b, st);
    exp_q.push_back({32'(b + MUL_LAT + 3), 5'd3, 32'd0});
    n_cmp++;
    if (start_cnt != s0) begin
      n_err++;
      $display("FAIL hit_no_start: got %0d pulses, required 0", start_cnt - s0);
    end
    run_to(b + MUL_LAT + 5);
    n_cmp++;
    if (start_cnt - s0 != 1 || last_start_cyc != b + 1) begin
      n_err++;
      $display("FAIL op_tag_miss: got %0d pulses last at %0d, required 1 at %0d",
               start_cnt - s0, last_start_cyc, b + 1);
    end
  endtask

  task automatic test_back_to_back();
    int a, b, s0;
    logic st;
    s0 = start_cnt;
    issue(2'b11, 32'd7, 32'd6, 5'd10, a, st);
    exp_q.push_back({32'(a + 1), 5'd10, 32'd0});
    tick();
    issue(2'b11, 32'd7, 32'd6, 5'd11, b, st);
    exp_q.push_back({32'(b + 1), 5'd11, 32'd0});
    n_cmp++;
    if (st !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: got stall %b at second accept, required 1", st);
    end
    run_to(b + 4);
    n_cmp++;
    if (start_cnt != s0) begin
      n_err++;
      $display("FAIL b2b_no_start: got %0d pulses, required 0", start_cnt - s0);
    end
  endtask

  task automatic test_flush_wait();
    int a, b, s0;
    logic st;
    s0 = start_cnt;
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, a, st);
    run_to(a + 10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run_to(a + 30);
    #1;
    n_cmp++;
    if (dbg_state !== 3'd3) begin
      n_err++;
      $display("FAIL flush_hold_wait: got state %0d, required 3", dbg_state);
    end
    run_to(a + MUL_LAT + 3);
    #1;
    n_cmp++;
    if (dbg_state !== 3'd4 || wb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_resp: got state %0d wb_valid %b, required 4/0", dbg_state, wb_valid);
    end
    tick();
    #1;
    n_cmp++;
    if (dbg_state !== 3'd0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle: got state %0d stall %b, required 0/0", dbg_state, stall);
    end
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, b, st);
    exp_q.push_back({32'(b + 1), 5'd12, 32'hFFFF_FFFE});
    run_to(b + 4);
    n_cmp++;
    if (start_cnt - s0 != 1) begin
      n_err++;
      $display("FAIL flush_cache_hit: got %0d pulses, required 1", start_cnt - s0);
    end
  endtask

  task automatic test_timeout();
    int a, s0, t0;
    logic st;
    s0 = start_cnt; t0 = to_cnt;
    mdl_silent = 1'b1;
    issue(2'b00, 32'd3, 32'd5, 5'd1, a, st);
    run_to(a + TIMEOUT + 4);
    #1;
    n_cmp++;
    if (to_cnt - t0 != 1 || last_to_cyc != a + TIMEOUT + 1) begin
      n_err++;
      $display("FAIL timeout_pulse: got %0d pulses last at %0d, required 1 at %0d",
               to_cnt - t0, last_to_cyc, a + TIMEOUT + 1);
    end
    n_cmp++;
    if (dbg_state !== 3'd0 || stall !== 1'b0 || dbg_cache_valid !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_after: got state %0d stall %b cache %b, required 0/0/0",
               dbg_state, stall, dbg_cache_valid);
    end
    n_cmp++;
    if (start_cnt - s0 != 1) begin
      n_err++;
      $display("FAIL timeout_single_start: got %0d pulses, required 1", start_cnt - s0);
    end
    mdl_silent = 1'b0;
  endtask

  task automatic test_rst_wait();
    int a, b, c, s0;
    logic st;
    issue(2'b00, 32'd2, 32'd9, 5'd4, a, st);
    exp_q.push_back({32'(a + MUL_LAT + 3), 5'd4, 32'd18});
    run_to(a + MUL_LAT + 5);
    issue(2'b00, 32'd2, 32'd10, 5'd6, b, st);
    run_to(b + 10);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({start_m, stall, wb_valid, timeout_err, m_op, m_opa, m_opb, wb_rd, wb_data} !== '0) begin
      n_err++;
      $display("FAIL rst_outputs: got stall %b opa %h opb %h rd %0d data %h, required all 0",
               stall, m_opa, m_opb, wb_rd, wb_data);
    end
    n_cmp++;
    if (dbg_state !== 3'd0 || dbg_cache_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_state: got state %0d cache %b, required 0/0", dbg_state, dbg_cache_valid);
    end
    tick(); tick();
    rst = 1'b0;
    run_to(cyc + 45);
    s0 = start_cnt;
    issue(2'b00, 32'd2, 32'd9, 5'd4, c, st);
    exp_q.push_back({32'(c + MUL_LAT + 3), 5'd4, 32'd18});
    run_to(c + MUL_LAT + 5);
    n_cmp++;
    if (start_cnt - s0 != 1 || last_start_cyc != c + 1) begin
      n_err++;
      $display("FAIL rst_then_miss: got %0d pulses last at %0d, required 1 at %0d",
               start_cnt - s0, last_start_cyc, c + 1);
    end
  endtask

  task automatic test_spurious_done();
    int a, s0;
    logic st;
    s0 = start_cnt;
    spur_done = 1'b1;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL spur_stall: got %b, required 0", stall);
    end
    tick();
    spur_done = 1'b0;
    #1;
    n_cmp++;
    if (dbg_state !== 3'd0 || dbg_cache_valid !== 1'b1) begin
      n_err++;
      $display("FAIL spur_state: got state %0d cache %b, required 0/1", dbg_state, dbg_cache_valid);
    end
    issue(2'b00, 32'd2, 32'd9, 5'd8, a, st);
    exp_q.push_back({32'(a + 1), 5'd8, 32'd18});
    run_to(a + 4);
    n_cmp++;
    if (start_cnt != s0) begin
      n_err++;
      $display("FAIL spur_cache_hit: got %0d pulses, required 0", start_cnt - s0);
    end
  endtask

  task automatic test_flush_hit_resp_idle();
    int a, b, c, s0;
    logic st;
    s0 = start_cnt;
    issue(2'b00, 32'd4, 32'd4, 5'd2, a, st);
    exp_q.push_back({32'(a + MUL_LAT + 3), 5'd2, 32'd16});
    run_to(a + MUL_LAT + 5);
    issue(2'b00, 32'd4, 32'd4, 5'd13, b, st);
    flush = 1'b1;
    #1;
    n_cmp++;
    if (wb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_hit: got wb_valid %b, required 0", wb_valid);
    end
    tick();
    flush = 1'b0;
    issue(2'b00, 32'd4, 32'd5, 5'd14, c, st);
    run_to(c + MUL_LAT + 3);
    flush = 1'b1;
    #1;
    n_cmp++;
    if (dbg_state !== 3'd4 || wb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_resp: got state %0d wb_valid %b, required 4/0", dbg_state, wb_valid);
    end
    tick();
    flush = 1'b0;
    ex_valid = 1'b1; ex_is_mul = 1'b1; ex_op = 2'b00; ex_rs1 = 32'd9; ex_rs2 = 32'd9;
    flush = 1'b1;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle_block: got stall %b, required 0", stall);
    end
    tick();
    ex_valid = 1'b0; ex_is_mul = 1'b0; flush = 1'b0;
    issue(2'b00, 32'd4, 32'd5, 5'd15, a, st);
    exp_q.push_back({32'(a + 1), 5'd15, 32'd20});
    run_to(a + 4);
    n_cmp++;
    if (start_cnt - s0 != 2) begin
      n_err++;
      $display("FAIL flush_starts: got %0d pulses, required 2", start_cnt - s0);
    end
  endtask

  task automatic test_random();
    int a, b, s0;
    logic st;
    logic [1:0] op;
    logic [31:0] x, y, r;
    logic [4:0] rd;
    for (int i = 0; i < 3; i++) begin
      op = 2'($urandom_range(0, 3));
      x = $urandom; y = $urandom;
      rd = 5'($urandom_range(1, 31));
      r = mul_ref(op, x, y);
      s0 = start_cnt;
      issue(op, x, y, rd, a, st);
      exp_q.push_back({32'(a + MUL_LAT + 3), rd, r});
      run_to(a + MUL_LAT + 5);
      issue(op, x, y, rd ^ 5'd1, b, st);
      exp_q.push_back({32'(b + 1), rd ^ 5'd1, r});
      run_to(b + 3);
      n_cmp++;
      if (start_cnt - s0 != 1) begin
        n_err++;
        $display("FAIL random_%0d_starts: got %0d pulses, required 1", i, start_cnt - s0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_miss_mul();
    test_hit_then_op_miss();
    test_back_to_back();
    test_flush_wait();
    test_timeout();
    test_rst_wait();
    test_spurious_done();
    test_flush_hit_resp_idle();
    test_random();
    run_to(cyc + 5);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending writebacks, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
